// File: rtl/soc_led_ctrl.sv
// soc_led_ctrl: memory-mapped LED controller supporting static, blink and PWM modes.
// Registers: 0x0 CTRL {LEVEL, MODE[1:0], EN}, 0x4 PERIOD, 0x8 DUTY, 0xC STATUS (toggle count).
// Optional build macro LED_PWM_EN: when defined, MODE=10 is 8-bit PWM dimming; when
// undefined, MODE=10 behaves as static and DUTY reads 0 and ignores writes.
module soc_led_ctrl #(
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned TCNT_W   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_we,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_led
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_DUTY   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [1:0] MODE_BLINK = 2'b01;
`ifdef LED_PWM_EN
  localparam logic [1:0] MODE_PWM   = 2'b10;
`endif

  logic [CTRL_W-1:0]   r_ctrl;
  logic [PERIOD_W-1:0] r_period;
  logic [TCNT_W-1:0]   r_status;
  logic [PERIOD_W-1:0] r_cnt;
  logic                r_blink_q;
  logic                r_led;
  logic                r_ready;
  logic [DATA_W-1:0]   r_rdata;
`ifdef LED_PWM_EN
  logic [7:0]          r_duty;
`endif

  logic                w_wr;
  logic                w_wr_ctrl;
  logic                w_wr_period;
  logic                w_wr_status;
  logic                w_restart;
  logic                w_en;
  logic                w_blink;
  logic                w_pwm;
  logic                w_enter_blink;
  logic                w_terminal;
  logic                w_led_dec;
  logic [PERIOD_W-1:0] w_cnt_nxt;
  logic [DATA_W-1:0]   w_rd_mux;
  logic                w_unused_bits;

  assign w_wr        = i_valid & i_we;
  assign w_wr_ctrl   = w_wr & (i_addr[3:2] == REG_CTRL);
  assign w_wr_period = w_wr & (i_addr[3:2] == REG_PERIOD);
  assign w_wr_status = w_wr & (i_addr[3:2] == REG_STATUS);
  assign w_restart   = w_wr_ctrl | w_wr_period;

  assign w_en    = r_ctrl[0];
  assign w_blink = w_en & (r_ctrl[2:1] == MODE_BLINK);
`ifdef LED_PWM_EN
  assign w_pwm   = w_en & (r_ctrl[2:1] == MODE_PWM);
`else
  assign w_pwm   = 1'b0;
`endif

  // Blink state reloads LEVEL only when blink mode is newly entered, not on every CTRL write
  assign w_enter_blink = w_wr_ctrl & i_wdata[0] & (i_wdata[2:1] == MODE_BLINK) & ~w_blink;
  assign w_terminal    = w_blink & (r_period != '0) & (r_cnt == r_period - PERIOD_W'(1));

  // Low address bits and unmapped data bits are intentionally ignored
  assign w_unused_bits = ^{i_addr[1:0], i_wdata};

  // Next blink/PWM counter value; bus writes to CTRL/PERIOD restart it
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_restart || !(w_blink || w_pwm)) begin
      w_cnt_nxt = '0;
    end else if (w_blink) begin
      if ((r_period == '0) || w_terminal) w_cnt_nxt = '0;
      else                                w_cnt_nxt = r_cnt + PERIOD_W'(1);
    end else begin
      if (r_cnt[7:0] == 8'hFF) w_cnt_nxt = '0;
      else                     w_cnt_nxt = r_cnt + PERIOD_W'(1);
    end
  end

  // LED decision for the current mode, registered into o_led next edge
  always_comb begin
    w_led_dec = 1'b0;
    if (w_en) begin
      if (w_blink) w_led_dec = r_blink_q;
`ifdef LED_PWM_EN
      else if (w_pwm) w_led_dec = (r_cnt[7:0] < r_duty);
`endif
      else w_led_dec = r_ctrl[3];
    end
  end

  // Register read mux
  always_comb begin
    w_rd_mux = '0;
    case (i_addr[3:2])
      REG_CTRL:   w_rd_mux = DATA_W'(r_ctrl);
      REG_PERIOD: w_rd_mux = DATA_W'(r_period);
`ifdef LED_PWM_EN
      REG_DUTY:   w_rd_mux = DATA_W'(r_duty);
`else
      REG_DUTY:   w_rd_mux = '0;
`endif
      REG_STATUS: w_rd_mux = DATA_W'(r_status);
      default:    w_rd_mux = '0;
    endcase
  end

  // Bus response: one-cycle ready pulse, read data only on reads
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= i_valid;
      r_rdata <= (i_valid && !i_we) ? w_rd_mux : '0;
    end
  end

  // Configuration registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ctrl   <= '0;
      r_period <= '0;
    end else begin
      if (w_wr_ctrl)   r_ctrl   <= i_wdata[CTRL_W-1:0];
      if (w_wr_period) r_period <= i_wdata[PERIOD_W-1:0];
    end
  end

`ifdef LED_PWM_EN
  // PWM compare register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_duty <= '0;
    end else if (w_wr & (i_addr[3:2] == REG_DUTY)) begin
      r_duty <= i_wdata[7:0];
    end
  end
`endif

  // Counter, blink state and LED output
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_blink_q <= 1'b0;
      r_led     <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_enter_blink)               r_blink_q <= i_wdata[3];
      else if (w_terminal && !w_restart) r_blink_q <= ~r_blink_q;
      r_led <= w_led_dec;
    end
  end

  // Saturating toggle counter; a STATUS write clears it and wins over a coincident toggle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_status <= '0;
    end else if (w_wr_status) begin
      r_status <= '0;
    end else if ((w_led_dec != r_led) && (r_status != '1)) begin
      r_status <= r_status + TCNT_W'(1);
    end
  end

  assign o_rdata = r_rdata;
  assign o_ready = r_ready;
  assign o_led   = r_led;

endmodule

// File: tb/tb_soc_led_ctrl.sv
// Self-checking bench for soc_led_ctrl: directed table, hand-written corner sequences,
// and randomized bus traffic compared every cycle against a behavioural model.
module tb_soc_led_ctrl;

  localparam int unsigned TB_PERIOD_W = 24;
  localparam int unsigned TB_TCNT_W   = 8;
  localparam int          STAT_MAX    = (1 << TB_TCNT_W) - 1;
  localparam int          NVEC        = 19;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_we = 1'b0;
  logic [3:0]  i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        o_led;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  soc_led_ctrl #(.PERIOD_W(TB_PERIOD_W), .TCNT_W(TB_TCNT_W)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_we    (i_we),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .o_rdata (o_rdata),
    .o_ready (o_ready),
    .o_led   (o_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Blink/PWM timing is tracked as "cycles elapsed since the last restart".
  logic [3:0]  m_ctrl = '0;
  logic [23:0] m_period = '0;
  logic [7:0]  m_duty = '0;
  int          m_status = 0;
  int          m_edges = 0;
  logic        m_bq = 1'b0;
  logic        m_led = 1'b0;
  logic        m_rdy = 1'b0;
  logic [31:0] m_rdata = '0;

  always @(posedge clk) begin : model
    logic en, blink, pwm, d, term, wc, wp, wd, ws, new_blink;
    logic [31:0] rv;
    if (i_rst) begin
      m_ctrl = '0; m_period = '0; m_duty = '0; m_status = 0; m_edges = 0;
      m_bq = 1'b0; m_led = 1'b0; m_rdy = 1'b0; m_rdata = '0;
    end else begin
      en    = m_ctrl[0];
      blink = en && (m_ctrl[2:1] == 2'b01);
`ifdef LED_PWM_EN
      pwm   = en && (m_ctrl[2:1] == 2'b10);
`else
      pwm   = 1'b0;
`endif
      if (!en)        d = 1'b0;
      else if (blink) d = m_bq;
      else if (pwm)   d = ((m_edges % 256) < int'(m_duty));
      else            d = m_ctrl[3];
      term = blink && (m_period != 0) && (((m_edges + 1) % int'(m_period)) == 0);
      wc = i_valid && i_we && (i_addr[3:2] == 2'd0);
      wp = i_valid && i_we && (i_addr[3:2] == 2'd1);
      wd = i_valid && i_we && (i_addr[3:2] == 2'd2);
      ws = i_valid && i_we && (i_addr[3:2] == 2'd3);
      case (i_addr[3:2])
        2'd0:    rv = {28'd0, m_ctrl};
        2'd1:    rv = {8'd0, m_period};
        2'd2:    rv = {24'd0, m_duty};
        default: rv = 32'(m_status);
      endcase
      m_rdy   = i_valid;
      m_rdata = (i_valid && !i_we) ? rv : 32'd0;
      if (ws)                                     m_status = 0;
      else if ((d != m_led) && (m_status < STAT_MAX)) m_status = m_status + 1;
      new_blink = i_wdata[0] && (i_wdata[2:1] == 2'b01);
      if (wc && !blink && new_blink) m_bq = i_wdata[3];
      else if (term && !(wc || wp))  m_bq = !m_bq;
      if (wc || wp)                                  m_edges = 0;
      else if ((blink && (m_period != 0)) || pwm)    m_edges = m_edges + 1;
      else                                           m_edges = 0;
      m_led = d;
      if (wc) m_ctrl = i_wdata[3:0];
      if (wp) m_period = i_wdata[23:0];
`ifdef LED_PWM_EN
      if (wd) m_duty = i_wdata[7:0];
`else
      if (wd) m_duty = m_duty;
`endif
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_led", 32'(o_led), 32'(m_led));
      chk("model_ready", 32'(o_ready), 32'(m_rdy));
      chk("model_rdata", o_rdata, m_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_acc(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic rdy);
    i_valid = 1'b1; i_we = we; i_addr = addr; i_wdata = wd;
    @(negedge clk);
    rd = o_rdata; rdy = o_ready;
    i_valid = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[NVEC];

`ifdef LED_PWM_EN
  localparam logic [31:0] DUTY_RB = 32'h0000_00A7;
`else
  localparam logic [31:0] DUTY_RB = 32'h0;
`endif

  initial begin
    logic [31:0] rd;
    logic        rdy;
    logic        stable;
    int          hi;

    tbl[0]  = '{1'b0, 4'h0, 32'h0,         32'h0};
    tbl[1]  = '{1'b0, 4'h4, 32'h0,         32'h0};
    tbl[2]  = '{1'b0, 4'h8, 32'h0,         32'h0};
    tbl[3]  = '{1'b0, 4'hC, 32'h0,         32'h0};
    tbl[4]  = '{1'b1, 4'h0, 32'hFFFF_FFF0, 32'h0};
    tbl[5]  = '{1'b0, 4'h0, 32'h0,         32'h0};
    tbl[6]  = '{1'b1, 4'h4, 32'hABCD_EF12, 32'h0};
    tbl[7]  = '{1'b0, 4'h5, 32'h0,         32'h00CD_EF12};
    tbl[8]  = '{1'b1, 4'h8, 32'h1234_56A7, 32'h0};
    tbl[9]  = '{1'b0, 4'hB, 32'h0,         DUTY_RB};
    tbl[10] = '{1'b1, 4'h0, 32'h0000_0009, 32'h0};
    tbl[11] = '{1'b0, 4'h2, 32'h0,         32'h9};
    tbl[12] = '{1'b1, 4'hD, 32'h0000_FFFF, 32'h0};
    tbl[13] = '{1'b0, 4'hC, 32'h0,         32'h0};
    tbl[14] = '{1'b1, 4'h0, 32'h0000_0006, 32'h0};
    tbl[15] = '{1'b0, 4'h0, 32'h0,         32'h6};
    tbl[16] = '{1'b0, 4'hC, 32'h0,         32'h1};
    tbl[17] = '{1'b1, 4'h4, 32'h0,         32'h0};
    tbl[18] = '{1'b1, 4'h8, 32'h0,         32'h0};

    // Reset held for two cycles
    i_rst = 1'b1;
    idle(2);
    chk("reset_led", 32'(o_led), 32'h0);
    chk("reset_ready", 32'(o_ready), 32'h0);
    chk("reset_rdata", o_rdata, 32'h0);
    chk_en = 1'b1;
    i_rst = 1'b0;

    // Register table
    for (int k = 0; k < NVEC; k++) begin
      do_acc(tbl[k].we, tbl[k].addr, tbl[k].wdata, rd, rdy);
      chk($sformatf("tbl%0d_ready", k), 32'(rdy), 32'h1);
      chk($sformatf("tbl%0d_rdata", k), rd, tbl[k].exp);
    end

    // Static mode and single-cycle ready pulse
    do_acc(1'b1, 4'h0, 32'h9, rd, rdy);
    chk("static_wr_ready", 32'(rdy), 32'h1);
    idle(1);
    chk("static_ready_drop", 32'(o_ready), 32'h0);
    chk("static_led", 32'(o_led), 32'h1);
    do_acc(1'b0, 4'h0, 32'h0, rd, rdy);
    chk("static_rd_ready", 32'(rdy), 32'h1);
    chk("static_rd_ctrl", rd, 32'h9);
    idle(1);
    chk("static_rd_ready_drop", 32'(o_ready), 32'h0);

    // Blink with period 4; STATUS clear coincides with the entry change
    do_acc(1'b1, 4'h4, 32'd4, rd, rdy);
    do_acc(1'b1, 4'h0, 32'h3, rd, rdy);
    do_acc(1'b1, 4'hC, 32'h0, rd, rdy);
    idle(40);
    do_acc(1'b0, 4'hC, 32'h0, rd, rdy);
    chk("blink_status10", rd, 32'd10);

    // Period 0 freezes the LED and STATUS
    do_acc(1'b1, 4'h4, 32'd0, rd, rdy);
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_led !== 1'b0) stable = 1'b0;
    end
    chk("p0_led_hold", 32'(stable), 32'h1);
    do_acc(1'b0, 4'hC, 32'h0, rd, rdy);
    chk("p0_status_hold", rd, 32'd10);

    // CTRL write on a terminal-count edge suppresses the toggle and restarts the count
    do_acc(1'b1, 4'h4, 32'd4, rd, rdy);
    idle(3);
    do_acc(1'b1, 4'h0, 32'h3, rd, rdy);
    idle(4);
    chk("term_wr_no_toggle", 32'(o_led), 32'h0);
    idle(1);
    chk("term_wr_restart", 32'(o_led), 32'h1);

    // STATUS saturation with a toggle every cycle
    do_acc(1'b1, 4'h4, 32'd1, rd, rdy);
    do_acc(1'b1, 4'hC, 32'h0, rd, rdy);
    idle(300);
    do_acc(1'b0, 4'hC, 32'h0, rd, rdy);
    chk("status_saturate", rd, 32'(STAT_MAX));
    do_acc(1'b1, 4'hC, 32'h0, rd, rdy);
    do_acc(1'b0, 4'hC, 32'h0, rd, rdy);
    chk("status_clear_wins", rd, 32'h0);

`ifdef LED_PWM_EN
    // PWM duty sweep over a full 256-cycle window
    do_acc(1'b1, 4'h8, 32'd64, rd, rdy);
    do_acc(1'b1, 4'h0, 32'h5, rd, rdy);
    idle(4);
    hi = 0;
    for (int k = 0; k < 256; k++) begin @(negedge clk); hi += int'(o_led); end
    chk("pwm_duty64", 32'(hi), 32'd64);
    do_acc(1'b1, 4'h8, 32'd0, rd, rdy);
    idle(4);
    hi = 0;
    for (int k = 0; k < 256; k++) begin @(negedge clk); hi += int'(o_led); end
    chk("pwm_duty0", 32'(hi), 32'd0);
    do_acc(1'b1, 4'h8, 32'd255, rd, rdy);
    idle(4);
    hi = 0;
    for (int k = 0; k < 256; k++) begin @(negedge clk); hi += int'(o_led); end
    chk("pwm_duty255", 32'(hi), 32'd255);
`else
    // Without PWM, MODE=10 is static and DUTY is inert
    do_acc(1'b1, 4'h8, 32'h40, rd, rdy);
    do_acc(1'b1, 4'h0, 32'hD, rd, rdy);
    idle(2);
    hi = 0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); hi += int'(o_led); end
    chk("nopwm_static_level", 32'(hi), 32'd20);
    do_acc(1'b0, 4'h8, 32'h0, rd, rdy);
    chk("nopwm_duty_reads0", rd, 32'h0);
`endif

    // Reset asserted during a blink together with a read
    do_acc(1'b1, 4'h4, 32'd3, rd, rdy);
    do_acc(1'b1, 4'h0, 32'hB, rd, rdy);
    idle(7);
    i_rst = 1'b1; i_valid = 1'b1; i_we = 1'b0; i_addr = 4'h4;
    @(negedge clk);
    chk("midrst_ready", 32'(o_ready), 32'h0);
    chk("midrst_led", 32'(o_led), 32'h0);
    chk("midrst_rdata", o_rdata, 32'h0);
    i_valid = 1'b0; i_addr = '0;
    idle(1);
    i_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_acc(1'b0, 4'(k * 4), 32'h0, rd, rdy);
      chk($sformatf("midrst_reg%0d", k), rd, 32'h0);
    end

    // Randomized traffic, checked each cycle against the model
    for (int k = 0; k < 4000; k++) begin
      logic [31:0] w;
      logic [3:0]  a;
      a = 4'($urandom);
      w = $urandom;
      if (a[3:2] == 2'd1) w[23:0] = 24'($urandom_range(0, 7));
      if (a[3:2] == 2'd0) w[0] = ($urandom_range(0, 3) != 0);
      i_rst   = ($urandom_range(0, 299) == 0);
      i_valid = ($urandom_range(0, 5) == 0);
      i_we    = 1'($urandom);
      i_addr  = a;
      i_wdata = w;
      @(negedge clk);
    end
    i_rst = 1'b0; i_valid = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
    idle(2);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/soc_led_ctrl.md
Name: soc_led_ctrl

Overview:
Memory-mapped LED controller peripheral inside the SoC top level; it is the stage that drives the top-level o_led pin probed by the SoC simulation bench. The core writes and reads it over the SoC's simple one-cycle peripheral bus. It supports three LED modes: static level, programmable-period blink, and 8-bit PWM dimming. A status register counts LED toggles, so firmware and the bench can check activity.

Parameters:
PERIOD_W, 24, width of blink half-period register/counter (cycles)
TCNT_W, 16, width of toggle counter in STATUS

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset
i_valid  input  1  bus request strobe (one cycle per access)
i_we  input  1  1 = write, 0 = read; sampled with i_valid
i_addr  input  4  byte address; bits [3:2] select register, [1:0] ignored
i_wdata  input  32  write data
o_rdata  output  32  read data, valid when o_ready=1, else 0
o_ready  output  1  access-complete pulse
o_led  output  1  LED drive, active-high

Behaviour:
- Clock/reset: one clock, i_clk; reset i_rst is synchronous and active-high. Reset clears all registers, counters and outputs: o_led=0, o_ready=0, o_rdata=0, CTRL=0, PERIOD=0, DUTY=0, STATUS=0.
- Register map (offset):
  0x0 CTRL (RW): bit0 EN, bits[2:1] MODE (00 static, 01 blink, 10 PWM, 11 reserved → static), bit3 LEVEL. Other bits read 0.
  0x4 PERIOD (RW): bits[PERIOD_W-1:0] blink half-period in cycles; upper bits read 0.
  0x8 DUTY (RW): bits[7:0] PWM compare; upper bits read 0.
  0xC STATUS (RO): bits[TCNT_W-1:0] toggle count; writing any value clears it to 0.
- Bus: every i_valid access completes in exactly one cycle. o_ready=1 in the cycle after i_valid, then 0. Writes take effect at that same edge. Reads return register contents as sampled at the i_valid edge. i_valid on back-to-back cycles is legal; each access gets its own o_ready pulse. There is no backpressure.
- o_led is registered in all modes, one cycle after the internal decision.
- EN=0: o_led=0; blink/PWM counters held at 0.
- Static (EN=1, MODE=00/11): o_led=LEVEL.
- Blink (MODE=01): counter runs 0..PERIOD-1. At count PERIOD-1 the LED toggles and the counter returns to 0, giving one toggle every PERIOD cycles. PERIOD=0 → LED holds its current value and the counter holds at 0. The LED starts at LEVEL when the mode is entered.
- PWM (MODE=10): free-running 8-bit counter wraps 255→0. o_led = (cnt < DUTY). DUTY=0 → always off; DUTY=255 → on 255 of every 256 cycles.
- Any write to CTRL or PERIOD resets the blink/PWM counter to 0 at that edge. When a write and a counter terminal event fall on the same edge, the write wins: no toggle occurs that cycle.
- STATUS increments on every cycle in which o_led changes value, in any mode. It saturates at all-ones and never wraps. A STATUS write coinciding with a toggle clears it to 0; the toggle is not counted.
- Reset asserted mid-access: o_ready is forced to 0 the next cycle and the access is dropped.

Optional Feature:
LED_PWM_EN. Defined: PWM mode is implemented as above. Undefined: the PWM counter and compare logic are omitted, MODE=10 behaves as static, and DUTY reads 0 and ignores writes.

Test Plan:
- Reset: hold i_rst 2 cycles → o_led=0, o_ready=0; reads of 0x0/0x4/0x8/0xC return 0.
- Static: write CTRL=0x9 (EN, static, LEVEL=1) → o_led=1 within 2 cycles of i_valid; read CTRL → o_rdata=0x9 with o_ready pulse exactly 1 cycle after i_valid.
- Blink: PERIOD=4, CTRL=0x3 → o_led toggles every 4 cycles; after 40 cycles STATUS reads 10. With PERIOD=0, o_led is held constant and STATUS stops counting.
- PWM (LED_PWM_EN defined): DUTY=64, CTRL=0x5 → o_led high for exactly 64 of every 256 cycles. DUTY=0 → o_led stays 0; DUTY=255 → one low cycle per 256.
- Boundaries: write CTRL on the same edge as a blink terminal count → no toggle and the counter restarts. STATUS preloaded near all-ones saturates and does not wrap. A STATUS write clears it.
- Mid-operation reset: assert i_rst during a blink and coincident with an i_valid read → o_led=0, no o_ready pulse, all registers 0 afterwards.
